// File: rtl/if_fetch_if.sv
// ============================================================================
// Module   : if_if_id (interface)
// Brief    : Fetch-to-decode pipeline register bundle carrying {inst, pc}.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_if_id #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;

    modport out    (output inst, output pc);
    modport in     (input  inst, input  pc);
    modport master (output inst, output pc);
    modport slave  (input  inst, input  pc);
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction fetch stage with a 2-entry fetched-word buffer,
//            IF/ID back-pressure and execute-stage redirect handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h8000_0000),
    parameter logic [XLEN-1:0] NOP_INST   = XLEN'(32'h0000_0013),
    parameter logic [XLEN-1:0] BUBBLE_PC  = XLEN'(32'hffff_ffff),
    parameter int              FIFO_DEPTH = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  wire logic            imem_gnt,
    input  wire logic            imem_rvalid,
    input  wire logic [XLEN-1:0] imem_rdata,
    input  wire logic            if_id_stalled,
    input  wire logic            redirect_valid,
    input  wire logic [XLEN-1:0] redirect_pc,
    if_if_id.out                 if_if_id_id
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_inst [FIFO_DEPTH];
    logic [XLEN-1:0] r_pc   [FIFO_DEPTH];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_count;

    logic            w_head_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_hs;
    logic [1:0]      w_count_after_pop;

    assign w_head_valid      = (r_count != 2'd0) && !redirect_valid;
    assign w_pop             = w_head_valid && !if_id_stalled;
    assign w_push            = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign w_count_after_pop = r_count - {1'b0, w_pop};
    assign w_hs              = imem_req && imem_gnt;

    assign if_if_id_id.inst = w_head_valid ? r_inst[r_rd_ptr] : NOP_INST;
    assign if_if_id_id.pc   = w_head_valid ? r_pc[r_rd_ptr]   : BUBBLE_PC;

    // Request is held off while reset is asserted so it reads low immediately.
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        imem_addr   = r_fetch_pc;
        case (r_state)
            S_REQ: begin
                imem_req = rst_n && (w_count_after_pop <= 2'd1);
                if (imem_req && imem_gnt) begin
                    w_state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end else if (redirect_valid) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_req_pc <= r_fetch_pc;
            end
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & c_ALIGN_MASK;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
                r_count    <= 2'd0;
            end else begin
                if (w_hs) begin
                    r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                end
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // Buffer payload needs no reset: it is only visible while r_count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wr_ptr] <= imem_rdata;
            r_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Randomised self-checking bench for if_fetch with a memory model
//            and a program-order scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch;

    localparam int          XLEN      = 32;
    localparam logic [31:0] c_RST_PC  = 32'h8000_0000;
    localparam logic [31:0] c_NOP     = 32'h0000_0013;
    localparam logic [31:0] c_BUBBLE  = 32'hffff_ffff;

    typedef struct packed {
        logic        mark;
        logic [31:0] pc;
        logic [31:0] inst;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_id_stalled = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    if_if_id #(.XLEN(XLEN)) u_if ();

    if_fetch #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_stalled  (if_id_stalled),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_if_id_id    (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // memory model knobs and state
    int          gnt_pct = 100;
    int          lat_lo  = 1;
    int          lat_hi  = 1;
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;
    int          proto_err = 0;

    // observations of the last step
    logic        obs_req, obs_hs;
    logic [31:0] obs_addr, obs_inst, obs_pc;
    ev_t         cons_q[$];
    ev_t         gnt_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Walks a log in program order: each redirect marker restarts the
    // expected address stream, every other entry must be the next word.
    function automatic int seq_errs(input bit use_gnt, output logic [31:0] act,
                                    output logic [31:0] expv);
        logic [31:0] e = c_RST_PC;
        int          errs = 0;
        int          n = use_gnt ? gnt_q.size() : cons_q.size();
        ev_t         ev;
        act  = 32'h0;
        expv = 32'h0;
        for (int i = 0; i < n; i++) begin
            ev = use_gnt ? gnt_q[i] : cons_q[i];
            if (ev.mark) begin
                e = ev.pc & 32'hffff_fffc;
            end else begin
                if (ev.pc !== e || (!use_gnt && ev.inst !== mem_word(ev.pc))) begin
                    if (errs == 0) begin
                        act  = ev.pc;
                        expv = e;
                    end
                    errs++;
                end
                e = e + 32'd4;
            end
        end
        return errs;
    endfunction

    task automatic step();
        imem_rvalid = mem_pend && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hdead_beef;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        obs_inst = u_if.inst;
        obs_pc   = u_if.pc;
        obs_hs   = imem_req && imem_gnt;
        if (obs_hs) begin
            if (mem_pend) proto_err++;
            gnt_q.push_back('{mark: 1'b0, pc: obs_addr, inst: 32'h0});
        end
        if (redirect_valid) begin
            gnt_q.push_back('{mark: 1'b1, pc: redirect_pc, inst: 32'h0});
            cons_q.push_back('{mark: 1'b1, pc: redirect_pc, inst: 32'h0});
        end else if (obs_pc !== c_BUBBLE && !if_id_stalled) begin
            cons_q.push_back('{mark: 1'b0, pc: obs_pc, inst: obs_inst});
        end
        @(posedge clk);
        if (imem_rvalid) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (obs_hs) begin
            mem_pend = 1'b1;
            mem_addr = obs_addr;
            mem_cnt  = $urandom_range(lat_hi - 1, lat_lo - 1);
        end
        @(negedge clk);
    endtask

    task automatic restart();
        rst_n          = 1'b0;
        if_id_stalled  = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        mem_pend       = 1'b0;
        proto_err      = 0;
        cons_q.delete();
        gnt_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] a, e;
        int          errs;
        rst_n = 1'b0;
        imem_gnt = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
        else n_pass++;
        n_checks++;
        if (u_if.pc !== c_BUBBLE || u_if.inst !== c_NOP)
            $display("FAIL reset_out: got %h/%h want %h/%h", u_if.inst, u_if.pc, c_NOP, c_BUBBLE);
        else n_pass++;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        restart();
        step();
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== c_RST_PC || obs_pc !== c_BUBBLE)
            $display("FAIL first_req: got req=%b addr=%h pc=%h want 1 %h %h", obs_req, obs_addr, obs_pc, c_RST_PC, c_BUBBLE);
        else n_pass++;
        step();
        n_checks++;
        if (obs_pc !== c_BUBBLE) $display("FAIL bubble_until_rvalid: got pc=%h want %h", obs_pc, c_BUBBLE);
        else n_pass++;
        step();
        n_checks++;
        if (obs_pc !== c_RST_PC || obs_inst !== mem_word(c_RST_PC))
            $display("FAIL first_inst: got %h/%h want %h/%h", obs_inst, obs_pc, mem_word(c_RST_PC), c_RST_PC);
        else n_pass++;
        repeat (12) step();
        errs = seq_errs(1'b1, a, e);
        n_checks++;
        if (errs !== 0 || gnt_q.size() < 6) $display("FAIL reset_addr_seq: got %h want %h (errs %0d)", a, e, errs);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] held, a, e;
        int          bad_req = 0, bad_pc = 0, errs;
        gnt_pct = 100; lat_lo = 1; lat_hi = 2;
        restart();
        repeat (5) step();
        if_id_stalled = 1'b1;
        repeat (6) step();
        held = obs_pc;
        repeat (5) begin
            step();
            if (obs_req !== 1'b0) bad_req++;
            if (obs_pc !== held || obs_pc === c_BUBBLE) bad_pc++;
        end
        n_checks++;
        if (bad_req !== 0) $display("FAIL stall_req: got %0d cycles with req want 0", bad_req);
        else n_pass++;
        n_checks++;
        if (bad_pc !== 0) $display("FAIL stall_head: got %0d unstable cycles want 0 (held %h)", bad_pc, held);
        else n_pass++;
        if_id_stalled = 1'b0;
        step();
        step();
        n_checks++;
        if (obs_pc !== held + 32'd4) $display("FAIL stall_second_entry: got %h want %h", obs_pc, held + 32'd4);
        else n_pass++;
        repeat (10) step();
        errs = seq_errs(1'b0, a, e);
        n_checks++;
        if (errs !== 0) $display("FAIL stall_no_loss: got %h want %h (errs %0d)", a, e, errs);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] a, e, first_new;
        int          k = 0, errs;
        bit          found = 1'b0;
        gnt_pct = 100; lat_lo = 3; lat_hi = 3;
        restart();
        repeat (4) step();
        while (!obs_hs && k < 20) begin step(); k++; end
        n_checks++;
        if (!obs_hs) $display("FAIL redir_wait_timeout: got no grant want grant");
        else n_pass++;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (obs_pc !== c_BUBBLE || obs_inst !== c_NOP)
            $display("FAIL redir_bubble: got %h/%h want %h/%h", obs_inst, obs_pc, c_NOP, c_BUBBLE);
        else n_pass++;
        k = gnt_q.size();
        repeat (12) step();
        first_new = 32'h0;
        for (int i = k; i < gnt_q.size(); i++)
            if (!found && !gnt_q[i].mark) begin first_new = gnt_q[i].pc; found = 1'b1; end
        n_checks++;
        if (first_new !== 32'h8000_0100) $display("FAIL redir_next_addr: got %h want 80000100", first_new);
        else n_pass++;
        errs = seq_errs(1'b0, a, e);
        n_checks++;
        if (errs !== 0) $display("FAIL redir_late_drop: got %h want %h (errs %0d)", a, e, errs);
        else n_pass++;
    endtask

    task automatic test_redirect_gnt();
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        restart();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0203;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (obs_hs !== 1'b1) $display("FAIL redir_gnt_hs: got %b want 1", obs_hs);
        else n_pass++;
        step();
        n_checks++;
        if (obs_req !== 1'b0) $display("FAIL drain_req: got %b want 0", obs_req);
        else n_pass++;
        step();
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h8000_0200)
            $display("FAIL drain_next_addr: got req=%b addr=%h want 1 80000200", obs_req, obs_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] a, e;
        int          errs, n0;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        restart();
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        step();
        redirect_valid = 1'b0;
        n0 = cons_q.size();
        repeat (14) step();
        n_checks++;
        if (cons_q.size() < n0 + 2 || cons_q[n0].pc !== 32'hffff_fffc || cons_q[n0+1].pc !== 32'h0000_0000)
            $display("FAIL wrap_pc: got %h,%h want fffffffc,00000000",
                     cons_q.size() > n0 ? cons_q[n0].pc : 32'hx, cons_q.size() > n0 + 1 ? cons_q[n0+1].pc : 32'hx);
        else n_pass++;
        errs = seq_errs(1'b1, a, e);
        n_checks++;
        if (errs !== 0) $display("FAIL wrap_addr_seq: got %h want %h (errs %0d)", a, e, errs);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] a, e;
        int          k = 0, errs;
        gnt_pct = 100; lat_lo = 3; lat_hi = 3;
        restart();
        repeat (4) step();
        while (!(obs_hs && obs_pc !== c_BUBBLE) && k < 30) begin step(); k++; end
        step();
        n_checks++;
        if (!mem_pend) $display("FAIL areset_setup: got idle want outstanding");
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || u_if.pc !== c_BUBBLE || u_if.inst !== c_NOP)
            $display("FAIL areset_out: got req=%b %h/%h want 0 %h/%h", imem_req, u_if.inst, u_if.pc, c_NOP, c_BUBBLE);
        else n_pass++;
        mem_pend = 1'b0;
        imem_rvalid = 1'b0;
        cons_q.delete();
        gnt_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== c_RST_PC)
            $display("FAIL areset_restart: got req=%b addr=%h want 1 %h", obs_req, obs_addr, c_RST_PC);
        else n_pass++;
        repeat (10) step();
        errs = seq_errs(1'b0, a, e);
        n_checks++;
        if (errs !== 0) $display("FAIL areset_seq: got %h want %h (errs %0d)", a, e, errs);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a, e;
        int          errs, words = 0;
        gnt_pct = 60; lat_lo = 1; lat_hi = 3;
        restart();
        repeat (800) begin
            if_id_stalled  = ($urandom_range(99) < 30);
            redirect_valid = ($urandom_range(99) < 3);
            redirect_pc    = ($urandom_range(1) == 1) ? $urandom : (32'hffff_fff0 | $urandom_range(15));
            step();
        end
        redirect_valid = 1'b0;
        if_id_stalled  = 1'b0;
        foreach (cons_q[i]) if (!cons_q[i].mark) words++;
        errs = seq_errs(1'b0, a, e);
        n_checks++;
        if (errs !== 0) $display("FAIL rand_cons_seq: got %h want %h (errs %0d)", a, e, errs);
        else n_pass++;
        errs = seq_errs(1'b1, a, e);
        n_checks++;
        if (errs !== 0) $display("FAIL rand_addr_seq: got %h want %h (errs %0d)", a, e, errs);
        else n_pass++;
        n_checks++;
        if (proto_err !== 0) $display("FAIL rand_outstanding: got %0d overlapping grants want 0", proto_err);
        else n_pass++;
        n_checks++;
        if (words < 50) $display("FAIL rand_progress: got %0d words want >= 50", words);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
